// File: rtl/xc20xx_lut_cfg_loader.sv
// Serial LUT4 INIT loader: hunts for an F2 preamble, reads a word count, then
// streams parity-protected 16-bit INIT words out as single-cycle write strobes.
module xc20xx_lut_cfg_loader #(
  parameter int NUM_LUTS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RESTART,
  input  logic              DIN,
  input  logic              DVALID,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [15:0]       WDATA,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [7:0] MAX_N = 8'(NUM_LUTS);

  function automatic logic even_parity_ok(input logic [15:0] data, input logic pbit);
    even_parity_ok = ~(^{data, pbit});
  endfunction

  logic [1:0]        r_sync;
  state_t            r_state,   w_state;
  logic [7:0]        r_hunt,    w_hunt;
  logic [7:0]        r_len,     w_len;
  logic [15:0]       r_shift,   w_shift;
  logic [4:0]        r_bitcnt,  w_bitcnt;
  logic [7:0]        r_wordcnt, w_wordcnt;
  logic              r_we,      w_we;
  logic [ADDR_W-1:0] r_waddr,   w_waddr;
  logic [15:0]       r_wdata,   w_wdata;
  logic              r_done,    w_done;
  logic              r_err,     w_err;
  logic              w_accept;
  logic [7:0]        w_hunt_shift;
  logic [7:0]        w_len_shift;

  // Reset release is resynchronised so no bit is taken until two edges later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign w_accept     = DVALID & r_sync[1];
  assign w_hunt_shift = {r_hunt[6:0], DIN};
  assign w_len_shift  = {r_len[6:0], DIN};

  // Next-state and datapath update.
  always_comb begin
    w_state   = r_state;
    w_hunt    = r_hunt;
    w_len     = r_len;
    w_shift   = r_shift;
    w_bitcnt  = r_bitcnt;
    w_wordcnt = r_wordcnt;
    w_we      = 1'b0;
    w_waddr   = r_waddr;
    w_wdata   = r_wdata;
    if (RESTART) begin
      w_state   = ST_HUNT;
      w_hunt    = 8'h00;
      w_len     = 8'h00;
      w_shift   = 16'h0000;
      w_bitcnt  = 5'd0;
      w_wordcnt = 8'd0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_accept) begin
            w_hunt = w_hunt_shift;
            if (w_hunt_shift == 8'hF2) begin
              w_state  = ST_LEN;
              w_bitcnt = 5'd0;
            end else begin
              w_state = ST_HUNT;
            end
          end else begin
            w_state = ST_HUNT;
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            w_len    = w_len_shift;
            w_bitcnt = r_bitcnt + 5'd1;
            if (r_bitcnt == 5'd7) begin
              w_bitcnt  = 5'd0;
              w_wordcnt = 8'd0;
              if ((w_len_shift != 8'd0) && (w_len_shift <= MAX_N)) begin
                w_state = ST_DATA;
              end else begin
                w_state = ST_ERROR;
              end
            end else begin
              w_state = ST_LEN;
            end
          end else begin
            w_state = ST_LEN;
          end
        end
        ST_DATA: begin
          // Word count reaching N means the final strobe went out last edge.
          if (r_wordcnt == r_len) begin
            w_state = ST_DONE;
          end else if (w_accept) begin
            if (r_bitcnt == 5'd16) begin
              w_bitcnt = 5'd0;
              if (even_parity_ok(r_shift, DIN)) begin
                w_we      = 1'b1;
                w_waddr   = r_wordcnt[ADDR_W-1:0];
                w_wdata   = r_shift;
                w_wordcnt = r_wordcnt + 8'd1;
              end else begin
                w_state = ST_ERROR;
              end
            end else begin
              w_shift  = {r_shift[14:0], DIN};
              w_bitcnt = r_bitcnt + 5'd1;
            end
          end else begin
            w_state = ST_DATA;
          end
        end
        ST_DONE:  w_state = ST_DONE;
        ST_ERROR: w_state = ST_ERROR;
        default:  w_state = ST_HUNT;
      endcase
    end
    w_done = (w_state == ST_DONE);
    w_err  = (w_state == ST_ERROR);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_HUNT;
      r_hunt    <= 8'h00;
      r_len     <= 8'h00;
      r_shift   <= 16'h0000;
      r_bitcnt  <= 5'd0;
      r_wordcnt <= 8'd0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= 16'h0000;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_hunt    <= w_hunt;
      r_len     <= w_len;
      r_shift   <= w_shift;
      r_bitcnt  <= w_bitcnt;
      r_wordcnt <= w_wordcnt;
      r_we      <= w_we;
      r_waddr   <= w_waddr;
      r_wdata   <= w_wdata;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  assign WE    = r_we;
  assign WADDR = r_waddr;
  assign WDATA = r_wdata;
  assign DONE  = r_done;
  assign ERR   = r_err;

endmodule

// File: tb/tb_xc20xx_lut_cfg_loader.sv
// Bench for xc20xx_lut_cfg_loader: table-driven loads, hand-written restart/reset
// sequences and random loads checked against a bit-stream parsing model.
module tb_xc20xx_lut_cfg_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RESTART = 1'b0;
  logic        DIN = 1'b0;
  logic        DVALID = 1'b0;
  logic        WE;
  logic [3:0]  WADDR;
  logic [15:0] WDATA;
  logic        DONE;
  logic        ERR;

  xc20xx_lut_cfg_loader #(.NUM_LUTS(16), .ADDR_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .RESTART(RESTART), .DIN(DIN), .DVALID(DVALID),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int nchecks = 0;
  int nerrs = 0;
  bit stall_en = 1'b0;
  bit acc[$];
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  int exp_status;
  int cyc = 0;
  int last_we_cyc = -10;
  int done_rise_cyc = -20;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;

  typedef struct {
    string            name;
    bit               noise;
    bit               stall;
    logic [7:0]       n;
    int               nw;
    logic [2:0][15:0] w;
    logic [15:0]      flip;
    int               exp_we;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchecks++;
    if (act !== expv) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Write-port monitor, sampled just after each rising edge.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (WE) begin
      chk("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
      got_q.push_back({4'h0, WADDR, WDATA});
      last_we_cyc = cyc;
    end
    if (DONE && !prev_done) done_rise_cyc = cyc;
    prev_we = WE;
    prev_done = DONE;
  end

  // Reference: parse the accepted bit stream directly.
  function automatic void run_model();
    int i;
    logic [7:0] h;
    int n;
    int d;
    int p;
    int ones;
    i = 0;
    h = 8'h00;
    exp_q.delete();
    exp_status = 0;
    while (i < acc.size() && h != 8'hF2) begin
      h = {h[6:0], acc[i]};
      i++;
    end
    if (h != 8'hF2 || acc.size() - i < 8) return;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      n = n * 2 + int'(acc[i]);
      i++;
    end
    if (n < 1 || n > 16) begin
      exp_status = 2;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (acc.size() - i < 17) return;
      d = 0;
      ones = 0;
      for (int k = 0; k < 16; k++) begin
        d = d * 2 + int'(acc[i]);
        ones += int'(acc[i]);
        i++;
      end
      p = int'(acc[i]);
      i++;
      if ((ones + p) % 2 != 0) begin
        exp_status = 2;
        return;
      end
      exp_q.push_back({8'(w), 16'(d)});
    end
    exp_status = 1;
  endfunction

  task automatic send_bit(input logic b);
    if (stall_en) begin
      repeat ($urandom_range(0, 3)) begin
        DVALID = 1'b0;
        DIN = 1'($urandom);
        @(negedge CLK);
      end
    end
    DIN = b;
    DVALID = 1'b1;
    acc.push_back(b);
    @(negedge CLK);
    DVALID = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_word(input logic [15:0] w, input logic flip);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
    send_bit((^w) ^ flip);
  endtask

  task automatic do_restart();
    RESTART = 1'b1;
    DVALID = 1'($urandom);
    DIN = 1'($urandom);
    @(negedge CLK);
    RESTART = 1'b0;
    DVALID = 1'b0;
    acc.delete();
    got_q.delete();
  endtask

  task automatic send_load(input bit noise, input logic [7:0] n, input int nw,
                           input logic [2:0][15:0] w, input logic [15:0] flip);
    logic [15:0] wd;
    if (noise) send_byte(8'hF3);
    send_byte(8'hF2);
    send_byte(n);
    for (int i = 0; i < nw; i++) begin
      wd = (i < 3) ? w[i] : 16'($urandom);
      send_word(wd, flip[i]);
    end
  endtask

  task automatic check_load(input string nm, input bit use_tab, input int exp_we,
                            input bit exp_done, input bit exp_err);
    DVALID = 1'b0;
    repeat (4) @(negedge CLK);
    run_model();
    chk({nm, "_we_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({nm, "_write"}, {8'h0, got_q[i]}, {8'h0, exp_q[i]});
    chk({nm, "_done"}, {31'd0, DONE}, (exp_status == 1) ? 32'd1 : 32'd0);
    chk({nm, "_err"}, {31'd0, ERR}, (exp_status == 2) ? 32'd1 : 32'd0);
    if (use_tab) begin
      chk({nm, "_tab_we"}, 32'(got_q.size()), 32'(exp_we));
      chk({nm, "_tab_done"}, {31'd0, DONE}, {31'd0, exp_done});
      chk({nm, "_tab_err"}, {31'd0, ERR}, {31'd0, exp_err});
    end
    if (exp_status == 1) chk({nm, "_done_latency"}, 32'(done_rise_cyc), 32'(last_we_cyc + 1));
  endtask

  function automatic vec_t mk(input string nm, input bit noise, input bit stall,
                              input logic [7:0] n, input int nw, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] flip, input int ew, input bit ed, input bit ee);
    vec_t v;
    v.name = nm; v.noise = noise; v.stall = stall; v.n = n; v.nw = nw;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.flip = flip;
    v.exp_we = ew; v.exp_done = ed; v.exp_err = ee;
    return v;
  endfunction

  vec_t tab[8];

  initial begin
    logic [2:0][15:0] rw;
    logic [15:0] rflip;
    int rn;

    tab[0] = mk("basic2",      1'b0, 1'b0, 8'd2,   2,  16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 2,  1'b1, 1'b0);
    tab[1] = mk("n_zero",      1'b0, 1'b0, 8'd0,   0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  1'b0, 1'b1);
    tab[2] = mk("n_17",        1'b0, 1'b0, 8'd17,  0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  1'b0, 1'b1);
    tab[3] = mk("bad_parity",  1'b0, 1'b0, 8'd1,   1,  16'hA5A5, 16'h0000, 16'h0000, 16'h0001, 0,  1'b0, 1'b1);
    tab[4] = mk("noise_stall", 1'b1, 1'b1, 8'd1,   1,  16'h1234, 16'h0000, 16'h0000, 16'h0000, 1,  1'b1, 1'b0);
    tab[5] = mk("n_max",       1'b0, 1'b1, 8'd16,  16, 16'h0F0F, 16'hC3C3, 16'h0001, 16'h0000, 16, 1'b1, 1'b0);
    tab[6] = mk("bad_mid",     1'b0, 1'b0, 8'd3,   2,  16'h1111, 16'h2222, 16'h0000, 16'h0002, 1,  1'b0, 1'b1);
    tab[7] = mk("n_255",       1'b0, 1'b0, 8'd255, 0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  1'b0, 1'b1);

    repeat (2) @(negedge CLK);
    chk("rst_we", {31'd0, WE}, 32'd0);
    chk("rst_waddr", {28'd0, WADDR}, 32'd0);
    chk("rst_wdata", {16'd0, WDATA}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    for (int t = 0; t < 8; t++) begin
      do_restart();
      stall_en = tab[t].stall;
      send_load(tab[t].noise, tab[t].n, tab[t].nw, tab[t].w, tab[t].flip);
      check_load(tab[t].name, 1'b1, tab[t].exp_we, tab[t].exp_done, tab[t].exp_err);
    end
    stall_en = 1'b0;

    // RESTART lands on the 10th data bit, then a clean load follows.
    do_restart();
    send_byte(8'hF2);
    send_byte(8'd1);
    for (int i = 15; i >= 7; i--) send_bit(1'b1);
    RESTART = 1'b1;
    DVALID = 1'b1;
    DIN = 1'b1;
    @(negedge CLK);
    RESTART = 1'b0;
    DVALID = 1'b0;
    acc.delete();
    got_q.delete();
    chk("restart_done", {31'd0, DONE}, 32'd0);
    chk("restart_err", {31'd0, ERR}, 32'd0);
    rw = '0;
    rw[0] = 16'h00FF;
    send_load(1'b0, 8'd1, 1, rw, 16'h0000);
    check_load("restart_reload", 1'b1, 1, 1'b1, 1'b0);
    if (got_q.size() > 0) chk("restart_reload_data", {16'd0, got_q[0][15:0]}, 32'h00FF);

    // Reset mid-load during word 2 of 3.
    do_restart();
    send_byte(8'hF2);
    send_byte(8'd3);
    send_word(16'hBEEF, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    chk("midrst_pre_we", 32'(got_q.size()), 32'd1);
    #3 RST_N = 1'b0;
    #2;
    chk("midrst_we", {31'd0, WE}, 32'd0);
    chk("midrst_waddr", {28'd0, WADDR}, 32'd0);
    chk("midrst_wdata", {16'd0, WDATA}, 32'd0);
    chk("midrst_done", {31'd0, DONE}, 32'd0);
    chk("midrst_err", {31'd0, ERR}, 32'd0);
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    acc.delete();
    got_q.delete();
    rw[0] = 16'h0001; rw[1] = 16'h7FFE; rw[2] = 16'hCAFE;
    send_load(1'b0, 8'd3, 3, rw, 16'h0000);
    check_load("post_reset_load", 1'b1, 3, 1'b1, 1'b0);

    // Random loads with noise prefixes, stalls and occasional parity faults.
    for (int r = 0; r < 8; r++) begin
      do_restart();
      stall_en = 1'($urandom);
      repeat ($urandom_range(0, 12)) send_bit(1'($urandom));
      rn = $urandom_range(1, 16);
      rw = {16'($urandom), 16'($urandom), 16'($urandom)};
      rflip = '0;
      for (int i = 0; i < 16; i++) rflip[i] = ($urandom_range(0, 9) == 0);
      send_load(1'b0, 8'(rn), rn, rw, rflip);
      check_load("random_load", 1'b0, 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
